ama_riscv_imm_enc: RTL and testbench

- Immediate encoder: the inverse of the immediate generator.
- Takes a 32-bit immediate, a format select and a 25-bit instruction template (bits [31:7]). Returns the template with that format's immediate fields overwritten.
- Used by the instruction-injection / self-test path to build branches, jumps and loads at run time.
- Two-stage valid/ready pipeline with range checking.

---
 rtl/ama_riscv_imm_enc_pkg.sv | 26 ++
 rtl/ama_riscv_imm_enc_if.sv | 30 +++
 rtl/ama_riscv_imm_enc_pack.sv | 52 +++++
 rtl/ama_riscv_imm_enc.sv | 92 +++++++++
 tb/tb_ama_riscv_imm_enc.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ama_riscv_imm_enc_pkg.sv
// Shared immediate-format select encodings, alignment constants and a sign-range helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package ama_riscv_imm_enc_pkg;

    typedef enum logic [2:0] {
        IG_DISABLED = 3'd0,
        IG_I_TYPE   = 3'd1,
        IG_S_TYPE   = 3'd2,
        IG_B_TYPE   = 3'd3,
        IG_J_TYPE   = 3'd4,
        IG_U_TYPE   = 3'd5
    } ig_sel_t;

    localparam int IMM_B_ALIGN = 1;
    localparam int IMM_J_ALIGN = 1;
    localparam int IMM_U_LOW_W = 12;

    // True when v[31:msb] are all equal, i.e. v is a sign extension from bit msb.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = 32'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/ama_riscv_imm_enc_if.sv
// Request/response bundle for the immediate encoder (valid/ready on both sides).
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry it; no buffering here.
interface ama_riscv_imm_enc_if #(
    parameter int ERR_CNT_W = 16
);
    import ama_riscv_imm_enc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    ig_sel_t              sel_in;
    logic [31:0]          imm_in;
    logic [31:7]          tmpl_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:7]          d_out;
    logic                 err_out;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, sel_in, imm_in, tmpl_in, out_ready,
        input  in_ready, out_valid, d_out, err_out, err_cnt
    );

    modport slave (
        input  in_valid, sel_in, imm_in, tmpl_in, out_ready,
        output in_ready, out_valid, d_out, err_out, err_cnt
    );

endinterface

// File: rtl/ama_riscv_imm_enc_pack.sv
// Overwrites the selected format's immediate fields in an instruction template and flags out-of-range immediates.
// Latency: purely combinational.
// Backpressure: none; illegal sel encodings pass the template through like IG_DISABLED.
module ama_riscv_imm_enc_pack
    import ama_riscv_imm_enc_pkg::*;
(
    input  ig_sel_t     sel,
    input  logic [31:0] imm,
    input  logic [31:7] tmpl,
    output logic [31:7] d,
    output logic        err
);

    always_comb begin
        d   = tmpl;
        err = 1'b0;
        case (sel)
            IG_I_TYPE: begin
                d[31:20] = imm[11:0];
                err      = !fits_signed(imm, 11);
            end
            IG_S_TYPE: begin
                d[31:25] = imm[11:5];
                d[11:7]  = imm[4:0];
                err      = !fits_signed(imm, 11);
            end
            IG_B_TYPE: begin
                d[31]    = imm[12];
                d[30:25] = imm[10:5];
                d[11:8]  = imm[4:1];
                d[7]     = imm[11];
                err      = !fits_signed(imm, 12) || (imm[IMM_B_ALIGN-1:0] != '0);
            end
            IG_J_TYPE: begin
                d[31]    = imm[20];
                d[30:21] = imm[10:1];
                d[20]    = imm[11];
                d[19:12] = imm[19:12];
                err      = !fits_signed(imm, 20) || (imm[IMM_J_ALIGN-1:0] != '0);
            end
            IG_U_TYPE: begin
                d[31:12] = imm[31:12];
                err      = (imm[IMM_U_LOW_W-1:0] != '0);
            end
            default: begin
                d   = tmpl;
                err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ama_riscv_imm_enc.sv
// Immediate encoder pipeline (inverse of the immediate generator); AMA_RISCV_IMM_ENC_ERR_CNT_EN adds a saturating error counter.
// Latency: 2 cycles accept-to-out_valid, 1 request per cycle.
// Backpressure: in_ready follows out_ready combinationally when both stages are full; no skid buffer.
module ama_riscv_imm_enc
    import ama_riscv_imm_enc_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    ama_riscv_imm_enc_if.slave    bus
);

    logic        s1_v;
    ig_sel_t     s1_sel;
    logic [31:0] s1_imm;
    logic [31:7] s1_tmpl;

    logic        s2_v;
    logic [31:7] s2_d;
    logic        s2_err;

    logic [31:7] pack_d;
    logic        pack_err;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv      = !s2_v || bus.out_ready;
    assign s1_adv      = !s1_v || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s1_sel  <= IG_DISABLED;
            s1_imm  <= '0;
            s1_tmpl <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sel  <= bus.sel_in;
                s1_imm  <= bus.imm_in;
                s1_tmpl <= bus.tmpl_in;
            end
        end
    end

    ama_riscv_imm_enc_pack u_pack (
        .sel  (s1_sel),
        .imm  (s1_imm),
        .tmpl (s1_tmpl),
        .d    (pack_d),
        .err  (pack_err)
    );

    // s2 data only loads alongside a valid s1 so a stalled result never changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v   <= 1'b0;
            s2_d   <= '0;
            s2_err <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_d   <= pack_d;
                s2_err <= pack_err;
            end
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.d_out     = s2_d;
    assign bus.err_out   = s2_err;

`ifdef AMA_RISCV_IMM_ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (s2_v && bus.out_ready && s2_err && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_imm_enc.sv
// Scoreboard bench for ama_riscv_imm_enc: directed vectors, toggling backpressure, mid-stream reset.
// Build with AMA_RISCV_IMM_ENC_ERR_CNT_EN to also exercise the saturating error counter (width 2).
module tb_ama_riscv_imm_enc;
    import ama_riscv_imm_enc_pkg::*;

`ifdef AMA_RISCV_IMM_ENC_ERR_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    typedef struct {
        logic [31:7] d;
        logic        err;
        int          acc;
        bit          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_mode = 0;
    int   pidx = 0;
    exp_t sb[$];

    ama_riscv_imm_enc_if #(.ERR_CNT_W(CW)) bus ();

    ama_riscv_imm_enc #(.ERR_CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // out_ready: 0 = always ready, 1 = 1,0,0 repeating, 2 = held low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       begin bus.out_ready = (pidx % 3 == 0); pidx++; end
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake, watches stall stability.
    initial begin
        logic        held;
        logic [31:7] held_d;
        logic        held_err;
        exp_t        e;
        held = 1'b0;
        held_d = '0;
        held_err = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1 || bus.out_valid !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_d_stable", {bus.d_out, 7'b0}, {held_d, 7'b0});
                    chk("stall_err_stable", 32'(bus.err_out), 32'(held_err));
                end
                if (bus.out_ready) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_d"}, {bus.d_out, 7'b0}, {e.d, 7'b0});
                        chk({e.name, "_err"}, 32'(bus.err_out), 32'(e.err));
                        if (e.lat) chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd2);
                    end
                end else begin
                    if (sb.size() >= 2) chk("in_ready_full_stall", 32'(bus.in_ready), 32'd0);
                    held     = 1'b1;
                    held_d   = bus.d_out;
                    held_err = bus.err_out;
                end
            end
        end
    end

    task automatic send(input string nm, input ig_sel_t sel, input logic [31:0] imm,
                        input logic [31:7] tmpl, input logic [31:0] exp_full,
                        input logic exp_err, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel_in   = sel;
        bus.imm_in   = imm;
        bus.tmpl_in  = tmpl;
        for (int w = 0; w < 100 && !done; w++) begin
            #2;
            if (bus.in_ready) begin
                e.d = exp_full[31:7];
                e.err = exp_err;
                e.acc = cyc;
                e.lat = lat;
                e.name = nm;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int w = 0; w < 200 && !empty; w++) begin
            @(negedge clk);
            #2;
            empty = (sb.size() == 0) && (bus.out_valid == 1'b0);
        end
        chk("drain", 32'(empty), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_d_out", {bus.d_out, 7'b0}, 32'd0);
        chk("async_rst_err_out", 32'(bus.err_out), 32'd0);
        sb.delete();
        @(negedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel_in   = IG_DISABLED;
        bus.imm_in   = '0;
        bus.tmpl_in  = '0;
        #3;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_d_out", {bus.d_out, 7'b0}, 32'd0);
        chk("reset_err_out", 32'(bus.err_out), 32'd0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        send("i_neg1",    IG_I_TYPE,   32'hFFFF_FFFF, 25'h0,       32'hFFF0_0000, 1'b0, 1'b1);
        send("s_neg2048", IG_S_TYPE,   32'hFFFF_F800, 25'h0,       32'h8000_0000, 1'b0, 1'b0);
        send("b_2048",    IG_B_TYPE,   32'h0000_0800, 25'h0,       32'h0000_0080, 1'b0, 1'b0);
        send("b_odd",     IG_B_TYPE,   32'h0000_0801, 25'h0,       32'h0000_0080, 1'b1, 1'b0);
        send("b_neg4096", IG_B_TYPE,   32'hFFFF_F000, 25'h0,       32'h8000_0000, 1'b0, 1'b0);
        send("j_max",     IG_J_TYPE,   32'h000F_FFFE, 25'h0,       32'h7FFF_F000, 1'b0, 1'b0);
        send("j_ovf",     IG_J_TYPE,   32'h0010_0000, 25'h0,       32'h8000_0000, 1'b1, 1'b0);
        send("u_ok",      IG_U_TYPE,   32'h1234_5000, 25'h0,       32'h1234_5000, 1'b0, 1'b0);
        send("u_low",     IG_U_TYPE,   32'h1234_5001, 25'h0,       32'h1234_5000, 1'b1, 1'b0);
        send("i_ovf",     IG_I_TYPE,   32'h0000_0800, 25'h0,       32'h8000_0000, 1'b1, 1'b0);
        send("disabled",  IG_DISABLED, 32'hDEAD_BEEF, 25'h1ABCDEF, {25'h1ABCDEF, 7'b0}, 1'b0, 1'b0);
        send("i_merge",   IG_I_TYPE,   32'h0000_0123, 25'h0001FFF, 32'h123F_FF80, 1'b0, 1'b0);
        send("sel_illegal", ig_sel_t'(3'd7), 32'h0000_0FFF, 25'h0A5A5A5, {25'h0A5A5A5, 7'b0}, 1'b0, 1'b0);
        drain();
`ifndef AMA_RISCV_IMM_ENC_ERR_CNT_EN
        chk("err_cnt_tied_off", 32'(bus.err_cnt), 32'd0);
`endif

        // Back-to-back stream against 1,0,0 backpressure; odd entries are misaligned U immediates.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send($sformatf("stream%0d", i), IG_U_TYPE, (32'(i + 1) << 12) | 32'(i & 1),
                 25'h0, 32'(i + 1) << 12, 1'(i & 1), 1'b0);
        end
        drain();

        // Two requests in flight with the consumer stalled, then reset.
        rdy_mode = 2;
        send("inflight0", IG_I_TYPE, 32'h0000_0001, 25'h0, 32'h0010_0000, 1'b0, 1'b0);
        send("inflight1", IG_I_TYPE, 32'h0000_0002, 25'h0, 32'h0020_0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pulse_reset();
        rdy_mode = 0;
        send("post_reset", IG_S_TYPE, 32'h0000_07FF, 25'h0, 32'h7E00_0F80, 1'b0, 1'b1);
        drain();

`ifdef AMA_RISCV_IMM_ENC_ERR_CNT_EN
        pulse_reset();
        chk("err_cnt_cleared", 32'(bus.err_cnt), 32'd0);
        rdy_mode = 2;
        send("cnt_stalled", IG_U_TYPE, 32'h0000_0001, 25'h0, 32'h0000_0000, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        #3;
        chk("err_cnt_during_stall", 32'(bus.err_cnt), 32'd0);
        rdy_mode = 0;
        drain();
        chk("err_cnt_once", 32'(bus.err_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send($sformatf("cnt%0d", i), IG_B_TYPE, 32'h0000_0003, 25'h0, 32'h0000_0100, 1'b1, 1'b0);
        end
        drain();
        chk("err_cnt_saturated", 32'(bus.err_cnt), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
